id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of the instruction-fetch stage.
- Holds the IF/ID pipeline register and a 32x32 register file with a write-back port.
- Decodes a fixed MIPS subset, resolves beq in ID and detects load-use and branch hazards.
- Drives a registered ID/EX bundle to the execute stage, plus stall/redirect signals back to fetch.

Parameters:
- NOP_WORD, 32'h00000000, instruction word inserted on flush/reset (decodes to all-controls-zero).
- REG_INIT, 32'h00000000, reset value of every register-file entry.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- instruction  in  32  word from fetch stage, valid every cycle.
- if_pc_plus4  in  32  address of instruction + 4, from fetch.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back register index.
- wb_data  in  32  write-back data.
- mem_reg_write  in  1  MEM-stage instruction writes a register.
- mem_dest  in  5  MEM-stage destination index.
- pc_stall  out  1  combinational; fetch must hold PC and current instruction.
- branch_taken  out  1  combinational; fetch loads branch_target (drives fetch control input).
- branch_target  out  32  combinational.
- ex_rs_data, ex_rt_data  out  32  registered operands.
- ex_imm  out  32  registered sign-extended immediate.
- ex_rs, ex_rt, ex_dest  out  5  registered indices; ex_dest = rd for R-type, rt for lw/addi, 0 otherwise.
- ex_alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  registered controls.

Behaviour:
- Reset (reset==0 at edge):
  - IF/ID instruction <= NOP_WORD; IF/ID pc <= 0.
  - All registered ex_* outputs <= 0.
  - All 32 registers <= REG_INIT.
  - Reset wins over every other event.
- IF/ID register:
  - No stall, no branch: loads instruction/if_pc_plus4.
  - pc_stall=1: holds.
  - branch_taken=1: loads NOP_WORD (flushes the wrong-path fetch).
- Register file:
  - r0 always reads 0; writes to r0 are ignored.
  - Write on edge when wb_we=1.
  - Write-through: a read of wb_addr in the same cycle as wb_we=1 returns wb_data (nonzero index only).
- Decode of the IF/ID word:
  - R-type op 000000, by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; reg_write=1, alu_src=0.
  - lw 100011: add, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
  - sw 101011: add, alu_src=1, mem_write=1.
  - addi 001000: add, alu_src=1, reg_write=1.
  - beq 000100: no ID/EX controls set.
  - Any other op/funct: all controls 0 (bubble).
  - Immediate: sign-extend bits[15:0] to 32 bits.
- Hazards (combinational, compared against the current ID/EX register contents):
  - load_use: ex_mem_read=1 and ex_dest!=0 and ex_dest equals decoded rs, or equals rt when the instruction reads rt (R-type, sw, beq).
  - br_haz: current instruction is beq and a nonzero rs/rt matches (ex_reg_write and ex_dest) or (mem_reg_write and mem_dest).
  - pc_stall = load_use | br_haz.
- Branch:
  - branch_taken = beq and rs_data==rt_data and !pc_stall.
  - branch_target = IF/ID pc + (imm << 2), 32-bit wrap-around, no overflow flag.
- ID/EX register:
  - pc_stall=1: all control bits <= 0 (bubble); data fields don't-care.
  - Otherwise: loads the decoded bundle.
- Latency: an instruction presented in cycle N appears on ex_* after the edge ending cycle N+1; branch_taken is visible during cycle N+1.
- Mid-operation reset: discards in-flight IF/ID and ID/EX content; no partial write-back is committed on that edge.

Test Plan:
- Reset: hold reset=0 two cycles with random instruction -> all ex_* = 0, pc_stall=0, branch_taken=0; read r5 afterwards -> 0.
- Write-through: wb_we=1, wb_addr=3, wb_data=32'h12345678, same cycle ID holds add r4,r3,r0 -> next edge ex_rs_data=32'h12345678, ex_alu_op=000, ex_dest=4, ex_reg_write=1.
- Write to r0: wb_we=1, wb_addr=0, wb_data=32'hFFFFFFFF, then add r1,r0,r0 -> ex_rs_data=0.
- Load-use: lw r2,4(r1) followed by add r3,r2,r1 -> pc_stall=1 for exactly one cycle, one bubble (all controls 0) in ID/EX, then add issues with ex_rs=2.
- beq taken: r1=r2=7, beq r1,r2,-2 at pc_plus4=32'h00000010 -> branch_taken=1, branch_target=32'h00000008; next cycle the IF/ID word is NOP_WORD.
- beq hazard plus unknown opcode: addi r1,r0,5 then beq r1,r0,1 -> pc_stall=1 while addi is in EX and while it is in MEM (mem_reg_write=1, mem_dest=1), then branch not taken; opcode 111111 -> all ex_* controls 0, no stall.

Source files
------------

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : MIPS-subset instruction-decode stage. Holds the IF/ID
//               register and a 32x32 register file with write-through,
//               resolves beq in ID, detects load-use and branch hazards,
//               and drives a registered ID/EX bundle to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter logic [31:0] REG_INIT = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] if_pc_plus4,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest,
    output logic        pc_stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic [2:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg
);

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_beq   = 6'b000100;

    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    // IF/ID register, register file and ID/EX register
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [31:0] ex_rs_data_q, ex_rs_data_d;
    logic [31:0] ex_rt_data_q, ex_rt_data_d;
    logic [31:0] ex_imm_q,     ex_imm_d;
    logic [4:0]  ex_rs_q,      ex_rs_d;
    logic [4:0]  ex_rt_q,      ex_rt_d;
    logic [4:0]  ex_dest_q,    ex_dest_d;
    logic [2:0]  ex_alu_op_q,  ex_alu_op_d;
    logic        ex_alu_src_q, ex_alu_src_d;
    logic        ex_mem_read_q,  ex_mem_read_d;
    logic        ex_mem_write_q, ex_mem_write_d;
    logic        ex_reg_write_q, ex_reg_write_d;
    logic        ex_mem_to_reg_q, ex_mem_to_reg_d;

    // Instruction fields
    logic [5:0]  w_opcode, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_imm;

    assign w_opcode = ifid_instr_q[31:26];
    assign w_rs     = ifid_instr_q[25:21];
    assign w_rt     = ifid_instr_q[20:16];
    assign w_rd     = ifid_instr_q[15:11];
    assign w_funct  = ifid_instr_q[5:0];
    assign w_imm    = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    // Decoded controls
    logic [2:0] w_alu_op;
    logic       w_alu_src, w_mem_read, w_mem_write, w_reg_write, w_mem_to_reg;
    logic [4:0] w_dest;
    logic       w_is_beq, w_reads_rt;

    // Decode the IF/ID word; anything unrecognised becomes a bubble
    always_comb begin
        w_alu_op     = 3'b000;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_dest       = 5'd0;
        w_is_beq     = 1'b0;
        w_reads_rt   = 1'b0;
        case (w_opcode)
            c_op_rtype: begin
                w_reads_rt  = 1'b1;
                w_reg_write = 1'b1;
                w_dest      = w_rd;
                case (w_funct)
                    c_fn_add: w_alu_op = 3'b000;
                    c_fn_sub: w_alu_op = 3'b001;
                    c_fn_and: w_alu_op = 3'b010;
                    c_fn_or:  w_alu_op = 3'b011;
                    c_fn_slt: w_alu_op = 3'b100;
                    default: begin
                        w_reg_write = 1'b0;
                        w_dest      = 5'd0;
                    end
                endcase
            end
            c_op_lw: begin
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_dest       = w_rt;
            end
            c_op_sw: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_reads_rt  = 1'b1;
            end
            c_op_addi: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_dest      = w_rt;
            end
            c_op_beq: begin
                w_is_beq   = 1'b1;
                w_reads_rt = 1'b1;
            end
            default: ;
        endcase
    end

    // Register read with r0 hard-wired to zero and write-through bypass
    logic [31:0] w_rs_data, w_rt_data;
    assign w_rs_data = (w_rs == 5'd0) ? 32'd0 :
                       (wb_we && (wb_addr == w_rs)) ? wb_data : regs_q[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? 32'd0 :
                       (wb_we && (wb_addr == w_rt)) ? wb_data : regs_q[w_rt];

    // Hazard detection against the instruction currently in EX (and MEM for beq)
    logic w_load_use, w_br_haz, w_rs_busy, w_rt_busy;
    always_comb begin
        w_load_use = ex_mem_read_q && (ex_dest_q != 5'd0) &&
                     ((ex_dest_q == w_rs) || (w_reads_rt && (ex_dest_q == w_rt)));
        w_rs_busy  = (w_rs != 5'd0) &&
                     ((ex_reg_write_q && (ex_dest_q == w_rs)) ||
                      (mem_reg_write && (mem_dest == w_rs)));
        w_rt_busy  = (w_rt != 5'd0) &&
                     ((ex_reg_write_q && (ex_dest_q == w_rt)) ||
                      (mem_reg_write && (mem_dest == w_rt)));
        w_br_haz   = w_is_beq && (w_rs_busy || w_rt_busy);
    end

    assign pc_stall      = w_load_use | w_br_haz;
    assign branch_taken  = w_is_beq && (w_rs_data == w_rt_data) && !pc_stall;
    assign branch_target = ifid_pc_q + (w_imm << 2);

    // IF/ID next state: flush on taken branch, hold on stall, else advance
    always_comb begin
        ifid_instr_d = instruction;
        ifid_pc_d    = if_pc_plus4;
        if (branch_taken) begin
            ifid_instr_d = NOP_WORD;
        end else if (pc_stall) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
        end
    end

    // Register-file write port; r0 is never written
    always_comb begin
        regs_d = regs_q;
        if (wb_we && (wb_addr != 5'd0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // ID/EX next state: stall inserts a bubble (controls and dest cleared)
    always_comb begin
        ex_rs_data_d    = w_rs_data;
        ex_rt_data_d    = w_rt_data;
        ex_imm_d        = w_imm;
        ex_rs_d         = w_rs;
        ex_rt_d         = w_rt;
        ex_dest_d       = w_dest;
        ex_alu_op_d     = w_alu_op;
        ex_alu_src_d    = w_alu_src;
        ex_mem_read_d   = w_mem_read;
        ex_mem_write_d  = w_mem_write;
        ex_reg_write_d  = w_reg_write;
        ex_mem_to_reg_d = w_mem_to_reg;
        if (pc_stall) begin
            ex_dest_d       = 5'd0;
            ex_alu_op_d     = 3'b000;
            ex_alu_src_d    = 1'b0;
            ex_mem_read_d   = 1'b0;
            ex_mem_write_d  = 1'b0;
            ex_reg_write_d  = 1'b0;
            ex_mem_to_reg_d = 1'b0;
        end
    end

    // State update; reset discards pipeline contents and any pending write-back
    always_ff @(posedge clk) begin
        if (!reset) begin
            ifid_instr_q    <= NOP_WORD;
            ifid_pc_q       <= 32'd0;
            for (int i = 0; i < 32; i++) regs_q[i] <= REG_INIT;
            ex_rs_data_q    <= 32'd0;
            ex_rt_data_q    <= 32'd0;
            ex_imm_q        <= 32'd0;
            ex_rs_q         <= 5'd0;
            ex_rt_q         <= 5'd0;
            ex_dest_q       <= 5'd0;
            ex_alu_op_q     <= 3'b000;
            ex_alu_src_q    <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
        end else begin
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            regs_q          <= regs_d;
            ex_rs_data_q    <= ex_rs_data_d;
            ex_rt_data_q    <= ex_rt_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_dest_q       <= ex_dest_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
        end
    end

    assign ex_rs_data    = ex_rs_data_q;
    assign ex_rt_data    = ex_rt_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs         = ex_rs_q;
    assign ex_rt         = ex_rt_q;
    assign ex_dest       = ex_dest_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Directed scoreboard bench for id_stage. The driver pushes
//               hand-computed expectations tagged with the cycle in which they
//               must hold; a monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, if_pc_plus4, wb_data;
    logic        wb_we, mem_reg_write;
    logic [4:0]  wb_addr, mem_dest;
    logic        pc_stall, branch_taken;
    logic [31:0] branch_target, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_dest;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;

    always #5 clk = ~clk;

    id_stage #(.NOP_WORD(32'h00000000), .REG_INIT(32'h00000000)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .if_pc_plus4(if_pc_plus4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .pc_stall(pc_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    localparam int S_CTRL  = 0;  // {alu_op, alu_src, mem_read, mem_write, reg_write, mem_to_reg}
    localparam int S_RSD   = 1;
    localparam int S_RTD   = 2;
    localparam int S_DEST  = 3;
    localparam int S_STALL = 4;
    localparam int S_TAKEN = 5;
    localparam int S_TGT   = 6;
    localparam int S_RS    = 7;
    localparam int S_IMM   = 8;

    // Control bundle encodings
    localparam logic [31:0] K_NONE = 32'h00;
    localparam logic [31:0] K_ADD  = 32'h02;
    localparam logic [31:0] K_SUB  = 32'h22;
    localparam logic [31:0] K_SLT  = 32'h82;
    localparam logic [31:0] K_LW   = 32'h1B;
    localparam logic [31:0] K_SW   = 32'h14;
    localparam logic [31:0] K_ADDI = 32'h12;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_CTRL:  return {24'd0, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
                             ex_reg_write, ex_mem_to_reg};
            S_RSD:   return ex_rs_data;
            S_RTD:   return ex_rt_data;
            S_DEST:  return {27'd0, ex_dest};
            S_STALL: return {31'd0, pc_stall};
            S_TAKEN: return {31'd0, branch_taken};
            S_TGT:   return branch_target;
            S_RS:    return {27'd0, ex_rs};
            default: return ex_imm;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int off, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc + off;
        e.sel = sel;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that falls due in the current cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = observe(sb[i].sel);
                n_vec++;
                if (got !== sb[i].val) begin
                    n_err++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h",
                             sb[i].nm, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; instruction = $urandom; if_pc_plus4 = 32'd0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mem_reg_write = 1'b0; mem_dest = 5'd0;

        next(); // cycle 1: still in reset
        instruction = $urandom;

        next(); // cycle 2: reset released
        n_vec++;
        if ({ex_reg_write, ex_mem_read} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_direct_ctrl: got %b, expected 00", {ex_reg_write, ex_mem_read});
        end
        n_vec++;
        if ({pc_stall, branch_taken} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_direct_hazard: got %b, expected 00", {pc_stall, branch_taken});
        end
        reset = 1'b1;
        instruction = rtype(5'd5, 5'd0, 5'd6, 6'b100000);            // add r6,r5,r0
        chk(0, S_CTRL, K_NONE, "reset_ctrl");
        chk(0, S_RSD, 32'd0, "reset_rs_data");
        chk(0, S_DEST, 32'd0, "reset_dest");
        chk(0, S_STALL, 32'd0, "reset_stall");
        chk(0, S_TAKEN, 32'd0, "reset_taken");
        chk(2, S_RSD, 32'd0, "r5_after_reset");
        chk(2, S_CTRL, K_ADD, "add_r6_ctrl");
        chk(2, S_DEST, 32'd6, "add_r6_dest");

        next(); // cycle 3
        instruction = rtype(5'd3, 5'd0, 5'd4, 6'b100000);            // add r4,r3,r0

        next(); // cycle 4: write-through of r3 while add r4 is in ID
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h12345678;
        instruction = rtype(5'd0, 5'd0, 5'd1, 6'b100000);            // add r1,r0,r0
        chk(1, S_RSD, 32'h12345678, "wt_rs_data");
        chk(1, S_CTRL, K_ADD, "wt_ctrl");
        chk(1, S_DEST, 32'd4, "wt_dest");

        next(); // cycle 5: write to r0 is ignored
        wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        instruction = rtype(5'd3, 5'd0, 5'd7, 6'b100010);            // sub r7,r3,r0
        chk(1, S_RSD, 32'd0, "r0_rs_data");
        chk(1, S_RTD, 32'd0, "r0_rt_data");
        chk(2, S_RSD, 32'h12345678, "r3_committed");
        chk(2, S_CTRL, K_SUB, "sub_ctrl");

        next(); // cycle 6
        wb_addr = 5'd1; wb_data = 32'd7;
        instruction = itype(6'b100011, 5'd1, 5'd2, 16'd4);           // lw r2,4(r1)

        next(); // cycle 7
        wb_addr = 5'd2; wb_data = 32'd7;
        instruction = rtype(5'd2, 5'd1, 5'd3, 6'b100000);            // add r3,r2,r1
        chk(0, S_STALL, 32'd0, "lw_in_id_nostall");
        chk(1, S_CTRL, K_LW, "lw_ctrl");
        chk(1, S_RSD, 32'd7, "lw_rs_data");
        chk(1, S_IMM, 32'd4, "lw_imm");
        chk(1, S_STALL, 32'd1, "load_use_stall");
        chk(2, S_STALL, 32'd0, "load_use_one_cycle");
        chk(2, S_CTRL, K_NONE, "load_use_bubble");
        chk(3, S_CTRL, K_ADD, "after_bubble_ctrl");
        chk(3, S_RS, 32'd2, "after_bubble_rs");
        chk(3, S_RSD, 32'd7, "after_bubble_rs_data");

        next(); // cycle 8: fetch holds during stall
        wb_we = 1'b0;

        next(); // cycle 9
        instruction = itype(6'b000100, 5'd1, 5'd2, 16'hFFFE);        // beq r1,r2,-2
        if_pc_plus4 = 32'h00000010;
        chk(1, S_TAKEN, 32'd1, "beq_taken");
        chk(1, S_TGT, 32'h00000008, "beq_target");
        chk(1, S_STALL, 32'd0, "beq_nostall");

        next(); // cycle 10: wrong-path fetch must be flushed
        instruction = itype(6'b001000, 5'd0, 5'd9, 16'd1);           // addi r9,r0,1
        if_pc_plus4 = 32'h00000014;
        chk(1, S_TAKEN, 32'd0, "flush_not_taken");
        chk(1, S_CTRL, K_NONE, "beq_ex_ctrl");
        chk(2, S_CTRL, K_NONE, "flushed_ctrl");
        chk(2, S_DEST, 32'd0, "flushed_dest");

        next(); // cycle 11
        instruction = itype(6'b001000, 5'd0, 5'd1, 16'd5);           // addi r1,r0,5
        if_pc_plus4 = 32'h0000001C;

        next(); // cycle 12
        instruction = itype(6'b000100, 5'd1, 5'd0, 16'd1);           // beq r1,r0,1
        if_pc_plus4 = 32'h00000020;
        chk(0, S_STALL, 32'd0, "addi_in_id_nostall");
        chk(1, S_STALL, 32'd1, "br_haz_ex");
        chk(1, S_CTRL, K_ADDI, "addi_ctrl");
        chk(1, S_DEST, 32'd1, "addi_dest");
        chk(1, S_IMM, 32'd5, "addi_imm");

        next(); // cycle 13: beq held by fetch

        next(); // cycle 14: addi now in MEM
        mem_reg_write = 1'b1; mem_dest = 5'd1;
        chk(0, S_STALL, 32'd1, "br_haz_mem");
        chk(0, S_CTRL, K_NONE, "br_haz_bubble");

        next(); // cycle 15: addi writes back, beq resolves not-taken
        mem_reg_write = 1'b0; mem_dest = 5'd0;
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
        instruction = 32'hFC221234;                                  // opcode 111111
        chk(0, S_STALL, 32'd0, "br_haz_clear");
        chk(0, S_TAKEN, 32'd0, "beq_not_taken");
        chk(1, S_CTRL, K_NONE, "beq2_ex_ctrl");
        chk(1, S_RS, 32'd1, "beq2_ex_rs");
        chk(1, S_STALL, 32'd0, "unknown_nostall");
        chk(2, S_CTRL, K_NONE, "unknown_ctrl");
        chk(2, S_DEST, 32'd0, "unknown_dest");

        next(); // cycle 16
        wb_we = 1'b0;
        instruction = itype(6'b101011, 5'd3, 5'd4, 16'hFFFC);        // sw r4,-4(r3)
        chk(2, S_CTRL, K_SW, "sw_ctrl");
        chk(2, S_IMM, 32'hFFFFFFFC, "sw_imm_sext");
        chk(2, S_RSD, 32'h12345678, "sw_rs_data");
        chk(2, S_DEST, 32'd0, "sw_dest");

        next(); // cycle 17
        instruction = rtype(5'd1, 5'd2, 5'd5, 6'b101010);            // slt r5,r1,r2
        chk(2, S_CTRL, K_SLT, "slt_ctrl");
        chk(2, S_RSD, 32'd5, "slt_rs_data");
        chk(2, S_RTD, 32'd7, "slt_rt_data");
        chk(2, S_DEST, 32'd5, "slt_dest");

        next(); // cycle 18
        instruction = rtype(5'd1, 5'd2, 5'd8, 6'b100101);            // or r8,r1,r2 (discarded)

        next(); // cycle 19: mid-operation reset with a pending write-back
        reset = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEADBEEF;
        instruction = rtype(5'd1, 5'd2, 5'd10, 6'b100100);           // and r10,r1,r2

        next(); // cycle 20
        reset = 1'b1; wb_we = 1'b0;
        instruction = rtype(5'd9, 5'd1, 5'd11, 6'b100000);           // add r11,r9,r1
        chk(0, S_CTRL, K_NONE, "midreset_ctrl");
        chk(0, S_DEST, 32'd0, "midreset_dest");
        chk(0, S_RSD, 32'd0, "midreset_rs_data");
        chk(0, S_STALL, 32'd0, "midreset_stall");
        chk(1, S_CTRL, K_NONE, "midreset_ifid_nop");
        chk(2, S_CTRL, K_ADD, "post_reset_ctrl");
        chk(2, S_DEST, 32'd11, "post_reset_dest");
        chk(2, S_RSD, 32'd0, "r9_not_committed");
        chk(2, S_RTD, 32'd0, "r1_reset");

        next(); // cycle 21
        instruction = 32'h00000000;
        repeat (4) next();

        while (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: never checked (due cycle %0d)", sb[0].nm, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
